spi_slave_calc: RTL

Parametrised SPI slave test target for chip-tester bring-up, generalising the fixed 8-bit-command / 24-bit-response square responder. All SPI pins are sampled in the system clock domain. Each transaction shifts in one command word, then shifts out a response word selected by an opcode field. Adds op modes, a transaction counter, tri-state enable, abort handling and a parallel monitor strobe.

---
 rtl/spi_slave_calc.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_calc.sv
// SPI slave calculator target: receives one command word, then returns an opcode-selected
// response word. All SPI pins are oversampled in the system clock domain.
module spi_slave_calc #(
    parameter int CMD_W  = 8,
    parameter int DATA_W = 24
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sclk,
    input  logic              sdi,
    input  logic              cs_n,
    output logic              sdo,
    output logic              sdo_oe,
    output logic              cmd_valid,
    output logic [CMD_W-1:0]  cmd_out,
    output logic [DATA_W-1:0] result_out,
    output logic [DATA_W-1:0] xfer_count
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        LOAD = 3'd2,
        RESP = 3'd3,
        DONE = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        sclk_sync_q, cs_sync_q, sdi_sync_q;
    logic              sclk_prev_q;
    logic [DATA_W-1:0] shift_q, shift_d, prev_q, prev_d;
    logic [DATA_W-1:0] result_q, result_d, count_q, count_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              sdo_q, sdo_d, oe_q, oe_d, valid_q, valid_d;
    logic              first_fall_q, first_fall_d, armed_q, armed_d;
    logic              sclk_rise_s, sclk_fall_s, cs_high_s, sdi_s;
    logic              cmd_done_s, resp_done_s;
    logic [CMD_W-1:0]  cmd_rx_s;
    logic [DATA_W-1:0] resp_s;

    function automatic logic [DATA_W-1:0] calc_resp(input logic [CMD_W-1:0]  cmd,
                                                     input logic [DATA_W-1:0] count,
                                                     input logic [DATA_W-1:0] prev);
        logic [DATA_W-1:0] arg_ext;
        arg_ext = DATA_W'(cmd[CMD_W-3:0]);
        case (cmd[CMD_W-1:CMD_W-2])
            2'b00:   calc_resp = arg_ext * arg_ext;
            2'b01:   calc_resp = arg_ext;
            2'b10:   calc_resp = count;
            2'b11:   calc_resp = prev;
            default: calc_resp = {DATA_W{1'b0}};
        endcase
    endfunction

    assign sclk_rise_s = sclk_sync_q[1] & ~sclk_prev_q;
    assign sclk_fall_s = ~sclk_sync_q[1] & sclk_prev_q;
    assign cs_high_s   = cs_sync_q[1];
    assign sdi_s       = sdi_sync_q[1];
    assign cmd_done_s  = (state_q == CMD) && sclk_rise_s && (bit_cnt_q == CNT_W'(CMD_W - 1));
    assign resp_done_s = (state_q == RESP) && sclk_rise_s && (bit_cnt_q == CNT_W'(DATA_W - 1));
    assign cmd_rx_s    = shift_q[CMD_W-1:0];
    assign resp_s      = calc_resp(cmd_rx_s, count_q, prev_q);

    // Register bank: synchronisers, FSM state and all datapath/output flops.
    // cs_n synchroniser resets low so a post-reset master must show cs_n high before arming.
    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_sync_q  <= 2'b00;
            cs_sync_q    <= 2'b00;
            sdi_sync_q   <= 2'b00;
            sclk_prev_q  <= 1'b0;
            state_q      <= IDLE;
            shift_q      <= {DATA_W{1'b0}};
            prev_q       <= {DATA_W{1'b0}};
            result_q     <= {DATA_W{1'b0}};
            count_q      <= {DATA_W{1'b0}};
            cmd_q        <= {CMD_W{1'b0}};
            bit_cnt_q    <= {CNT_W{1'b0}};
            sdo_q        <= 1'b0;
            oe_q         <= 1'b0;
            valid_q      <= 1'b0;
            first_fall_q <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[0], sclk};
            cs_sync_q    <= {cs_sync_q[0], cs_n};
            sdi_sync_q   <= {sdi_sync_q[0], sdi};
            sclk_prev_q  <= sclk_sync_q[1];
            state_q      <= state_d;
            shift_q      <= shift_d;
            prev_q       <= prev_d;
            result_q     <= result_d;
            count_q      <= count_d;
            cmd_q        <= cmd_d;
            bit_cnt_q    <= bit_cnt_d;
            sdo_q        <= sdo_d;
            oe_q         <= oe_d;
            valid_q      <= valid_d;
            first_fall_q <= first_fall_d;
            armed_q      <= armed_d;
        end
    end

    // Next-state logic; a high cs_n overrides any sclk edge in the same cycle.
    always_comb begin
        state_d = state_q;
        if (cs_high_s) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = armed_q ? CMD : IDLE;
                CMD:     state_d = cmd_done_s ? LOAD : CMD;
                LOAD:    state_d = RESP;
                RESP:    state_d = resp_done_s ? DONE : RESP;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath and registered output values per state.
    always_comb begin
        shift_d      = shift_q;
        prev_d       = prev_q;
        result_d     = result_q;
        count_d      = count_q;
        cmd_d        = cmd_q;
        bit_cnt_d    = bit_cnt_q;
        sdo_d        = sdo_q;
        oe_d         = oe_q;
        valid_d      = 1'b0;
        first_fall_d = first_fall_q;
        if (cs_high_s) begin
            armed_d = 1'b1;
        end else if (state_q == IDLE) begin
            armed_d = armed_q;
        end else begin
            armed_d = 1'b0;
        end
        if (cs_high_s) begin
            sdo_d        = 1'b0;
            oe_d         = 1'b0;
            bit_cnt_d    = {CNT_W{1'b0}};
            first_fall_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    sdo_d     = 1'b0;
                    oe_d      = 1'b0;
                    bit_cnt_d = {CNT_W{1'b0}};
                end
                CMD: begin
                    if (sclk_rise_s) begin
                        shift_d   = {shift_q[DATA_W-2:0], sdi_s};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end
                LOAD: begin
                    shift_d      = resp_s;
                    sdo_d        = resp_s[DATA_W-1];
                    oe_d         = 1'b1;
                    cmd_d        = cmd_rx_s;
                    result_d     = resp_s;
                    prev_d       = resp_s;
                    valid_d      = 1'b1;
                    count_d      = count_q + DATA_W'(1);
                    bit_cnt_d    = {CNT_W{1'b0}};
                    first_fall_d = 1'b1;
                end
                RESP: begin
                    // MSB is already on sdo when RESP starts, so the first fall only arms shifting.
                    if (sclk_fall_s && first_fall_q) begin
                        first_fall_d = 1'b0;
                    end else if (sclk_fall_s) begin
                        shift_d = {shift_q[DATA_W-2:0], 1'b0};
                        sdo_d   = shift_q[DATA_W-2];
                    end else if (resp_done_s) begin
                        sdo_d     = 1'b0;
                        bit_cnt_d = {CNT_W{1'b0}};
                    end else if (sclk_rise_s) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end else begin
                        sdo_d = sdo_q;
                    end
                end
                DONE: begin
                    sdo_d = 1'b0;
                    oe_d  = 1'b1;
                end
                default: begin
                    sdo_d = 1'b0;
                    oe_d  = 1'b0;
                end
            endcase
        end
    end

    assign sdo        = sdo_q;
    assign sdo_oe     = oe_q;
    assign cmd_valid  = valid_q;
    assign cmd_out    = cmd_q;
    assign result_out = result_q;
    assign xfer_count = count_q;
endmodule
